// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Write-port controller for the 32x32 register file. Two requesters share the
// single write port: the pipeline write-back stage (wb) and the multi-cycle
// unit (mu). wb has priority unless mu has been refused STARVE_MAX cycles in a
// row, in which case mu is forced through for one transfer. On clr_req the
// block walks x1..x31 through the write port writing zero.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   clr_req                    level request to start a clear sequence
//   clr_busy                   high while the clear sequence is running
//   clr_done                   registered one-cycle pulse with the x31 write
//   wb_valid/ready/rd/data     write-back stage request + handshake
//   mu_valid/ready/rd/data     multi-cycle unit request + handshake
//   W_en, Rd, Wr_data          registered register-file write port
//   grant_src                  registered source of the write (0 wb, 1 mu)
//
// State table
//   ST_ARB   | normal arbitration between wb and mu
//   ST_CLEAR | zeroing x1..x31, both requesters held off
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_req,
    output logic        clr_busy,
    output logic        clr_done,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        mu_valid,
    output logic        mu_ready,
    input  logic [4:0]  mu_rd,
    input  logic [31:0] mu_data,
    output logic        W_en,
    output logic [4:0]  Rd,
    output logic [31:0] Wr_data,
    output logic        grant_src
);

    localparam logic [3:0] LP_SMAX = 4'(STARVE_MAX);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t     r_state;
    logic [4:0] r_clr_idx;
    logic [3:0] r_starve_cnt;

    logic w_force_mu;
    logic w_arb_open;
    logic w_wb_xfer;
    logic w_mu_xfer;

    assign w_force_mu = mu_valid && (r_starve_cnt == LP_SMAX);

    // Readies are gated by rst_n so nothing handshakes while reset is held.
    assign w_arb_open = rst_n && (r_state == ST_ARB) && !clr_req;
    assign wb_ready   = w_arb_open && !w_force_mu;
    assign mu_ready   = w_arb_open && (!wb_valid || w_force_mu);

    assign w_wb_xfer  = wb_valid && wb_ready;
    assign w_mu_xfer  = mu_valid && mu_ready;

    assign clr_busy   = (r_state == ST_CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_ARB;
            r_clr_idx    <= 5'd0;
            r_starve_cnt <= 4'd0;
            W_en         <= 1'b0;
            Rd           <= 5'd0;
            Wr_data      <= 32'd0;
            grant_src    <= 1'b0;
            clr_done     <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (r_state)
                ST_ARB: begin
                    // Starvation counts only cycles where wb is what blocked mu.
                    if (w_mu_xfer || !mu_valid) begin
                        r_starve_cnt <= 4'd0;
                    end else if (wb_valid && (r_starve_cnt != LP_SMAX)) begin
                        r_starve_cnt <= r_starve_cnt + 4'd1;
                    end

                    if (clr_req) begin
                        r_state   <= ST_CLEAR;
                        r_clr_idx <= 5'd1;
                        W_en      <= 1'b0;
                    end else if (w_wb_xfer) begin
                        W_en      <= (wb_rd != 5'd0);
                        Rd        <= wb_rd;
                        Wr_data   <= wb_data;
                        grant_src <= 1'b0;
                    end else if (w_mu_xfer) begin
                        W_en      <= (mu_rd != 5'd0);
                        Rd        <= mu_rd;
                        Wr_data   <= mu_data;
                        grant_src <= 1'b1;
                    end else begin
                        W_en      <= 1'b0;
                    end
                end

                ST_CLEAR: begin
                    W_en      <= 1'b1;
                    Rd        <= r_clr_idx;
                    Wr_data   <= 32'd0;
                    grant_src <= 1'b0;
                    r_clr_idx <= r_clr_idx + 5'd1;
                    if (r_clr_idx == 5'd31) begin
                        r_state  <= ST_ARB;
                        clr_done <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Directed bench for rf_wb_arbiter (STARVE_MAX = 4): a vector table for the
// single-cycle arbitration behaviour, followed by hand-written sequences for
// reset, the clear walk and reset in the middle of a clear.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_done;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mu_valid;
    logic        mu_ready;
    logic [4:0]  mu_rd;
    logic [31:0] mu_data;
    logic        W_en;
    logic [4:0]  Rd;
    logic [31:0] Wr_data;
    logic        grant_src;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .mu_valid  (mu_valid),
        .mu_ready  (mu_ready),
        .mu_rd     (mu_rd),
        .mu_data   (mu_data),
        .W_en      (W_en),
        .Rd        (Rd),
        .Wr_data   (Wr_data),
        .grant_src (grant_src)
    );

    typedef struct packed {
        logic        clr_req;
        logic        wb_valid;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        mu_valid;
        logic [4:0]  mu_rd;
        logic [31:0] mu_data;
        logic        e_wb_ready;
        logic        e_mu_ready;
        logic        e_wen;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_gs;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic wv, input logic [4:0] wr, input logic [31:0] wd,
        input logic mv, input logic [4:0] mr, input logic [31:0] md,
        input logic ewr, input logic emr, input logic ew,
        input logic [4:0] er, input logic [31:0] ed, input logic eg);
        vec_t v;
        v.clr_req    = 1'b0;
        v.wb_valid   = wv;
        v.wb_rd      = wr;
        v.wb_data    = wd;
        v.mu_valid   = mv;
        v.mu_rd      = mr;
        v.mu_data    = md;
        v.e_wb_ready = ewr;
        v.e_mu_ready = emr;
        v.e_wen      = ew;
        v.e_rd       = er;
        v.e_data     = ed;
        v.e_gs       = eg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        clr_req  = v.clr_req;
        wb_valid = v.wb_valid;
        wb_rd    = v.wb_rd;
        wb_data  = v.wb_data;
        mu_valid = v.mu_valid;
        mu_rd    = v.mu_rd;
        mu_data  = v.mu_data;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " W_en"},      32'(W_en),      32'd0);
        chk({tag, " Rd"},        32'(Rd),        32'd0);
        chk({tag, " Wr_data"},   Wr_data,        32'd0);
        chk({tag, " grant_src"}, 32'(grant_src), 32'd0);
        chk({tag, " clr_done"},  32'(clr_done),  32'd0);
        chk({tag, " clr_busy"},  32'(clr_busy),  32'd0);
        chk({tag, " wb_ready"},  32'(wb_ready),  32'd0);
        chk({tag, " mu_ready"},  32'(mu_ready),  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Vector table. Both-valid contention uses wb(10,A0) / mu(20,B0).
        vecs[0]  = mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,  1, 0, 1, 5'd5, 32'hDEADBEEF, 0);
        vecs[1]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 1, 0, 5'd5, 32'hDEADBEEF, 0);
        vecs[2]  = mk(0, 5'd0, 32'h0,        1, 5'd0, 32'h1234, 1, 1, 0, 5'd0, 32'h1234, 1);
        vecs[3]  = mk(0, 5'd0, 32'h0,        1, 5'd7, 32'h77, 1, 1, 1, 5'd7, 32'h77, 1);
        for (int i = 4; i <= 13; i++) begin
            if (((i - 4) % 5) == 4)
                vecs[i] = mk(1, 5'd10, 32'hA0, 1, 5'd20, 32'hB0, 0, 1, 1, 5'd20, 32'hB0, 1);
            else
                vecs[i] = mk(1, 5'd10, 32'hA0, 1, 5'd20, 32'hB0, 1, 0, 1, 5'd10, 32'hA0, 0);
        end
        vecs[14] = mk(1, 5'd0, 32'h55, 0, 5'd0, 32'h0, 1, 0, 0, 5'd0, 32'h55, 0);
        vecs[15] = mk(1, 5'd1, 32'h11, 0, 5'd0, 32'h0, 1, 0, 1, 5'd1, 32'h11, 0);
        vecs[16] = mk(1, 5'd2, 32'h22, 0, 5'd0, 32'h0, 1, 0, 1, 5'd2, 32'h22, 0);
        vecs[17] = mk(1, 5'd3, 32'h33, 0, 5'd0, 32'h0, 1, 0, 1, 5'd3, 32'h33, 0);
        vecs[18] = mk(1, 5'd4, 32'h44, 1, 5'd9, 32'h99, 1, 0, 1, 5'd4, 32'h44, 0);
        vecs[19] = mk(0, 5'd0, 32'h0,  1, 5'd9, 32'h99, 1, 1, 1, 5'd9, 32'h99, 1);
        vecs[20] = mk(1, 5'd4, 32'h44, 1, 5'd9, 32'h99, 1, 0, 1, 5'd4, 32'h44, 0);
        vecs[21] = mk(1, 5'd4, 32'h44, 1, 5'd9, 32'h99, 1, 0, 1, 5'd4, 32'h44, 0);
        vecs[22] = mk(1, 5'd6, 32'h66, 0, 5'd0, 32'h0,  1, 0, 1, 5'd6, 32'h66, 0);
        vecs[23] = mk(1, 5'd4, 32'h44, 1, 5'd9, 32'h99, 1, 0, 1, 5'd4, 32'h44, 0);

        rst_n    = 1'b0;
        clr_req  = 1'b0;
        wb_valid = 1'b0;
        wb_rd    = 5'd0;
        wb_data  = 32'd0;
        mu_valid = 1'b0;
        mu_rd    = 5'd0;
        mu_data  = 32'd0;
        #1;
        chk_all_zero("reset");
        step();
        step();
        rst_n = 1'b1;

        // Table-driven arbitration
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d wb_ready", i), 32'(wb_ready), 32'(vecs[i].e_wb_ready));
            chk($sformatf("v%0d mu_ready", i), 32'(mu_ready), 32'(vecs[i].e_mu_ready));
            step();
            chk($sformatf("v%0d W_en", i),      32'(W_en),      32'(vecs[i].e_wen));
            chk($sformatf("v%0d Rd", i),        32'(Rd),        32'(vecs[i].e_rd));
            chk($sformatf("v%0d Wr_data", i),   Wr_data,        vecs[i].e_data);
            chk($sformatf("v%0d grant_src", i), 32'(grant_src), 32'(vecs[i].e_gs));
            chk($sformatf("v%0d clr_done", i),  32'(clr_done),  32'd0);
        end

        // Reset mid-stream (both requesters still valid, Rd=4/data=0x44 held)
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        step();
        rst_n    = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        mu_valid = 1'b0;
        #1;
        chk("postrst wb_ready", 32'(wb_ready), 32'd1);
        step();
        chk("postrst W_en",      32'(W_en),      32'd1);
        chk("postrst Rd",        32'(Rd),        32'd5);
        chk("postrst Wr_data",   Wr_data,        32'hDEADBEEF);
        chk("postrst grant_src", 32'(grant_src), 32'd0);

        // Clear sequence with wb held valid; cycle T starts here
        clr_req = 1'b1; wb_rd = 5'd12; wb_data = 32'h0000000C;
        #1;
        chk("clrT wb_ready", 32'(wb_ready), 32'd0);
        chk("clrT clr_busy", 32'(clr_busy), 32'd0);
        step();
        clr_req = 1'b0;
        #1;
        chk("clrT1 clr_busy", 32'(clr_busy), 32'd1);
        chk("clrT1 wb_ready", 32'(wb_ready), 32'd0);
        chk("clrT1 W_en",     32'(W_en),     32'd0);
        for (int k = 2; k <= 32; k++) begin
            step();
            chk($sformatf("clr T+%0d W_en", k),     32'(W_en),     32'd1);
            chk($sformatf("clr T+%0d Rd", k),       32'(Rd),       32'(k - 1));
            chk($sformatf("clr T+%0d Wr_data", k),  Wr_data,       32'd0);
            chk($sformatf("clr T+%0d clr_done", k), 32'(clr_done), 32'(k == 32));
            chk($sformatf("clr T+%0d clr_busy", k), 32'(clr_busy), 32'(k <= 31));
            chk($sformatf("clr T+%0d wb_ready", k), 32'(wb_ready), 32'(k == 32));
        end
        step();
        chk("clrT33 W_en",     32'(W_en),     32'd1);
        chk("clrT33 Rd",       32'(Rd),       32'd12);
        chk("clrT33 Wr_data",  Wr_data,       32'h0000000C);
        chk("clrT33 clr_done", 32'(clr_done), 32'd0);

        // Build starve_cnt to 3, then start a clear with both valid (count -> 4)
        wb_rd = 5'd10; wb_data = 32'hA0;
        mu_valid = 1'b1; mu_rd = 5'd20; mu_data = 32'hB0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("pre wb_ready %0d", i), 32'(wb_ready), 32'd1);
            step();
        end
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("mc T+10 Rd", 32'(Rd), 32'd9);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mcrst");
        step();
        step();
        rst_n = 1'b1;
        // Counter must restart at 0: four wb grants, then one forced mu grant
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("mc arb%0d wb_ready", i), 32'(wb_ready), 32'(i != 4));
            chk($sformatf("mc arb%0d mu_ready", i), 32'(mu_ready), 32'(i == 4));
            step();
            chk($sformatf("mc arb%0d Rd", i),        32'(Rd),        (i == 4) ? 32'd20 : 32'd10);
            chk($sformatf("mc arb%0d grant_src", i), 32'(grant_src), 32'(i == 4));
            chk($sformatf("mc arb%0d clr_busy", i),  32'(clr_busy),  32'd0);
            chk($sformatf("mc arb%0d clr_done", i),  32'(clr_done),  32'd0);
        end
        wb_valid = 1'b0;
        mu_valid = 1'b0;
        step();
        for (int i = 0; i < 25; i++) begin
            step();
            chk($sformatf("mc idle%0d W_en", i),     32'(W_en),     32'd0);
            chk($sformatf("mc idle%0d clr_done", i), 32'(clr_done), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
